// File: rtl/hd_timing_pkg.sv
// Shared constants, enums and raster helpers for the HD video timing generator.
// The 1080p60 defaults live here so every instance agrees on the raster.
package hd_timing_pkg;

   localparam int DEF_H_ACTIVE = 1920;
   localparam int DEF_H_FP     = 88;
   localparam int DEF_H_SYNC   = 44;
   localparam int DEF_H_BP     = 148;
   localparam int DEF_V_ACTIVE = 1080;
   localparam int DEF_V_FP     = 4;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 36;

   typedef enum logic [1:0] {ACT, FP, SYNC, BP} axis_phase_e;
   typedef enum logic [1:0] {UNLOCKED, TRACKING, LOCKED} lock_state_e;

   function automatic int h_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

   // Phase that owns a given position on an axis; used when the V counter is reloaded.
   function automatic axis_phase_e phase_at(int pos, int active, int fp, int sync);
      axis_phase_e ph;
      if (pos < active)                 ph = ACT;
      else if (pos < active + fp)       ph = FP;
      else if (pos < active + fp + sync) ph = SYNC;
      else                              ph = BP;
      return ph;
   endfunction

endpackage

// File: rtl/hd_video_timing_gen_if.sv
// Raster signal bundle between the timing generator (master) and its consumer (slave).
interface hd_video_timing_gen_if;

   logic        i_frame_end;
   logic        o_hd_clk;
   logic        o_hd_hsync;
   logic        o_hd_vsync;
   logic        o_hd_de;
   logic [11:0] o_h_count;
   logic [11:0] o_v_count;
   logic        o_frame_start;
   logic        o_locked;

   modport master (
      input  i_frame_end,
      output o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de,
      output o_h_count, o_v_count, o_frame_start, o_locked
   );

   modport slave (
      output i_frame_end,
      input  o_hd_clk, o_hd_hsync, o_hd_vsync, o_hd_de,
      input  o_h_count, o_v_count, o_frame_start, o_locked
   );

endinterface

// File: rtl/hd_axis_counter.sv
// One raster axis: 12-bit position counter with a registered ACT/FP/SYNC/BP phase,
// advance enable, wrap pulse and a synchronous (value, phase) load.
module hd_axis_counter
   import hd_timing_pkg::*;
#(
   parameter int ACT_LEN  = 16,
   parameter int FP_LEN   = 2,
   parameter int SYNC_LEN = 3,
   parameter int BP_LEN   = 3
) (
   input  logic        clk_out,
   input  logic        reset,
   input  logic        adv,
   input  logic        load,
   input  logic [11:0] load_val,
   input  axis_phase_e load_phase,
   output logic [11:0] count,
   output axis_phase_e phase,
   output logic        wrap
);

   localparam int          TOTAL    = h_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);
   localparam logic [11:0] END_ACT  = 12'(ACT_LEN - 1);
   localparam logic [11:0] END_FP   = 12'(ACT_LEN + FP_LEN - 1);
   localparam logic [11:0] END_SYNC = 12'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
   localparam logic [11:0] LAST     = 12'(TOTAL - 1);

   assign wrap = adv && (count == LAST);

   // NOTE: non-blocking assignments so count and phase both see the pre-edge state.
   always_ff @(posedge clk_out) begin
      if (reset) begin
         count <= '0;
         phase <= ACT;
      end else if (load) begin
         count <= load_val;
         phase <= load_phase;
      end else if (adv) begin
         count <= wrap ? 12'd0 : count + 12'd1;
         unique case (phase)
            ACT:  if (count == END_ACT)  phase <= FP;
            FP:   if (count == END_FP)   phase <= SYNC;
            SYNC: if (count == END_SYNC) phase <= BP;
            BP:   if (count == LAST)     phase <= ACT;
         endcase
      end
   end

endmodule

// File: rtl/hd_video_timing_gen.sv
// HD raster timing generator: pixel divider, H/V axis counters and registered syncs.
// Define HD_TIMING_FRAME_LOCK_EN to slave the vertical position to i_frame_end.
module hd_video_timing_gen
   import hd_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic SYNC_POL  = 1'b1,
   parameter int   CLK_DIV   = 2,
   parameter int   LOCK_LINE = 1100,
   parameter int   LOCK_TOL  = 2
) (
   input  logic                 clk_out,
   input  logic                 reset,
   hd_video_timing_gen_if.master vid
);

   localparam int                H_TOTAL    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int                V_TOTAL    = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int                DIV_W      = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(CLK_DIV / 2);
   localparam logic [11:0]       LOCK_V     = 12'(LOCK_LINE);
   localparam axis_phase_e       LOCK_PHASE = phase_at(LOCK_LINE, V_ACTIVE, V_FP, V_SYNC);

   if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
      $error("hd_video_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counters");
   end
   if (CLK_DIV < 2) begin : g_div_check
      $error("hd_video_timing_gen: CLK_DIV must be at least 2");
   end
   if (LOCK_LINE >= V_TOTAL || 2 * LOCK_TOL >= V_TOTAL) begin : g_lock_check
      $error("hd_video_timing_gen: LOCK_LINE/LOCK_TOL outside the frame");
   end

   logic [DIV_W-1:0] div;
   logic             pix_en;
   logic [11:0]      h_count, v_count;
   axis_phase_e      h_phase, v_phase;
   logic             line_start;
   logic             v_load;
   logic             v_wrap_unused;
   logic             locked;

   assign pix_en = (div == DIV_LAST);

   always_ff @(posedge clk_out) begin
      if (reset)       div <= '0;
      else if (pix_en) div <= '0;
      else             div <= div + DIV_W'(1);
   end

   hd_axis_counter #(
      .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)
   ) u_h_axis (
      .clk_out(clk_out), .reset(reset), .adv(pix_en), .load(1'b0),
      .load_val(12'd0), .load_phase(ACT),
      .count(h_count), .phase(h_phase), .wrap(line_start)
   );

   hd_axis_counter #(
      .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)
   ) u_v_axis (
      .clk_out(clk_out), .reset(reset), .adv(line_start), .load(v_load),
      .load_val(LOCK_V), .load_phase(LOCK_PHASE),
      .count(v_count), .phase(v_phase), .wrap(v_wrap_unused)
   );

`ifdef HD_TIMING_FRAME_LOCK_EN
   localparam logic [12:0] V_TOTAL13 = 13'(V_TOTAL);
   localparam logic [12:0] LOCK_V13  = 13'(LOCK_LINE);
   localparam logic [11:0] TOL12     = 12'(LOCK_TOL);
   localparam logic [11:0] GOOD_HI   = 12'(V_TOTAL - LOCK_TOL);

   lock_state_e lock_state;
   logic        pending;
   logic [1:0]  good_cnt;
   logic [12:0] err_raw;
   logic [11:0] err_mod;
   logic        frame_good;

   // Line error folded into [0, V_TOTAL); the top TOL values are the negative errors.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      err_raw    = {1'b0, v_count} + V_TOTAL13 - LOCK_V13;
      err_mod    = err_raw[11:0];
      if (err_raw >= V_TOTAL13) err_mod = 12'(err_raw - V_TOTAL13);
      frame_good = (err_mod <= TOL12) || (err_mod >= GOOD_HI);
   end

   assign v_load = line_start && pending && !frame_good;

   always_ff @(posedge clk_out) begin
      if (reset) begin
         lock_state <= UNLOCKED;
         pending    <= 1'b0;
         good_cnt   <= '0;
      end else if (line_start) begin
         // A pulse coincident with line_start is held for the next one.
         pending <= vid.i_frame_end;
         if (pending) begin
            if (!frame_good) begin
               lock_state <= UNLOCKED;
               good_cnt   <= '0;
            end else begin
               case (lock_state)
                  UNLOCKED: begin
                     lock_state <= TRACKING;
                     good_cnt   <= '0;
                  end
                  TRACKING: begin
                     if (good_cnt == 2'd3) lock_state <= LOCKED;
                     else                  good_cnt   <= good_cnt + 2'd1;
                  end
                  default: lock_state <= LOCKED;
               endcase
            end
         end
      end else if (vid.i_frame_end) begin
         pending <= 1'b1;
      end
   end

   assign locked = (lock_state == LOCKED);
`else
   logic frame_end_unused;
   assign frame_end_unused = vid.i_frame_end;
   assign v_load           = 1'b0;
   assign locked           = 1'b0;
`endif

   logic hd_clk_q, hsync_q, vsync_q, de_q, frame_start_q;

   always_ff @(posedge clk_out) begin
      if (reset) begin
         hd_clk_q      <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         de_q          <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hd_clk_q      <= (div < DIV_HALF);
         hsync_q       <= (h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
         vsync_q       <= (v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
         de_q          <= (h_phase == ACT) && (v_phase == ACT);
         frame_start_q <= pix_en && (h_count == 12'd0) && (v_count == 12'd0);
      end
   end

   assign vid.o_hd_clk      = hd_clk_q;
   assign vid.o_hd_hsync    = hsync_q;
   assign vid.o_hd_vsync    = vsync_q;
   assign vid.o_hd_de       = de_q;
   assign vid.o_h_count     = h_count;
   assign vid.o_v_count     = v_count;
   assign vid.o_frame_start = frame_start_q;
   assign vid.o_locked      = locked;

endmodule

// File: doc/hd_video_timing_gen.md
Name: hd_video_timing_gen

Overview:
- Generates the HD raster timing that the PAL line-buffer upsampler reads against: pixel strobe (o_hd_clk), hsync, vsync and data-enable for the ADV7511 path.
- Free-running 4-phase horizontal/vertical counters.
- Optionally frame-locks its vertical position to the upsampler's o_frame_end pulse so HD frames track the PAL/NTSC source.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (pixels)
- H_SYNC, 44, hsync width (pixels)
- H_BP, 148, horizontal back porch (pixels)
- V_ACTIVE, 1080, active lines
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync
- CLK_DIV, 2, clk_out cycles per pixel (>=2)
- LOCK_LINE, 1100, target v count at which i_frame_end should land
- LOCK_TOL, 2, allowed line error for lock

Ports:
- clk_out  in  1  HD domain clock
- reset  in  1  synchronous, active-high
- i_frame_end  in  1  one-cycle pulse, clk_out domain, from upsampler
- o_hd_clk  out  1  pixel strobe; high for first CLK_DIV/2 cycles of each pixel
- o_hd_hsync  out  1  horizontal sync, polarity SYNC_POL
- o_hd_vsync  out  1  vertical sync, polarity SYNC_POL
- o_hd_de  out  1  data enable
- o_h_count  out  12  current pixel index
- o_v_count  out  12  current line index
- o_frame_start  out  1  one-cycle pulse at pixel (0,0)
- o_locked  out  1  frame lock achieved

Behaviour:
- Reset values: counters 0; divider 0; o_hd_clk 0; syncs = ~SYNC_POL; o_hd_de 0; o_frame_start 0; o_locked 0; lock state UNLOCKED. Reset asserted mid-frame returns all of these on the next edge.
- Divider counts 0..CLK_DIV-1. pix_en is asserted when the divider equals CLK_DIV-1. Counters advance only on pix_en.
- Horizontal FSM H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT, with durations from the parameters. h count wraps at H_TOTAL-1 to 0, producing line_start.
- Vertical FSM V_ACT -> V_FP -> V_SYNC -> V_BP. It advances only on line_start and wraps at V_TOTAL-1.
- Outputs are registered with 1 clk_out of latency from counter state:
  - de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vsync changes only at h = 0
- o_frame_start: one-cycle pulse on the pix_en that enters h = 0, v = 0.
- Width rules: all counters are 12-bit unsigned. H_TOTAL and V_TOTAL must be <= 4096; this is checked by an elaboration assertion.

Optional Feature:
- Macro HD_TIMING_FRAME_LOCK_EN.
- When defined:
  - i_frame_end sets a pending flag. Several pulses before the next line_start collapse to one.
  - A pulse arriving on the same cycle as line_start is applied at the following line_start.
  - At line_start with the flag pending, compute err = (v - LOCK_LINE) mod V_TOTAL, mapped to the signed range.
  - If |err| <= LOCK_TOL, the frame is good and no adjustment is made.
  - Otherwise v is loaded with LOCK_LINE (the V FSM phase is recomputed), the good count is cleared, and state goes to UNLOCKED.
  - Lock FSM is UNLOCKED -> TRACKING on the first good frame, and TRACKING -> LOCKED after 4 consecutive good frames.
  - Any bad frame from TRACKING or LOCKED goes to UNLOCKED. o_locked = (state == LOCKED).
- When undefined: i_frame_end ignored, free-running raster, o_locked tied 0.

Decomposition:
- Package hd_timing_pkg holds:
  - 1080p60 default constants
  - H_TOTAL/V_TOTAL derivation functions
  - axis phase enum {ACT, FP, SYNC, BP}
  - lock state enum {UNLOCKED, TRACKING, LOCKED}
- Sub-module hd_axis_counter: one 4-phase counter with advance-enable, wrap pulse, and synchronous load (value, phase). Instantiated for the H and V axes.

Test Plan (sim params: H 16/2/3/3 giving H_TOTAL 24; V 8/1/2/1 giving V_TOTAL 12; CLK_DIV 2; LOCK_LINE 10; LOCK_TOL 1):
- Release reset -> o_hd_clk toggles every cycle; first o_frame_start 2 cycles after release; frame period 576 clk_out.
- Free run -> de high for 16 of every 24 pixels on lines 0-7; hsync = SYNC_POL at h 18-20; vsync = SYNC_POL on lines 9-10, changing only at h = 0.
- Assert reset at v = 5, h = 7 -> next edge all outputs at reset values; counting restarts from (0,0).
- Lock enabled, i_frame_end at v = 10 every frame -> o_locked rises at line_start of the 5th pulse; no v jump occurs.
- Locked, then one i_frame_end at v = 3 -> at next line_start v is loaded to 10 and o_locked falls; 2 pulses in one line count as a single event.
- Macro undefined, i_frame_end pulsed randomly -> raster identical to free run; o_locked constant 0.
